// File: rtl/decode_stage_n.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | decode_stage_n : N-lane decode with taken-lane masking, bogus-taken        |
// |                  redirect and a valid/ready output pipeline register.      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+

package decode_pkg;
  localparam int CTRL_BUS = 8;
  localparam int c_cond_branch = 0;
  localparam int c_jal         = 1;
  localparam int c_jalr        = 2;
  localparam int c_load        = 3;
  localparam int c_store       = 4;
  localparam int c_alu         = 5;
  localparam int c_upper       = 6;
  localparam int c_illegal     = 7;
  localparam logic [6:0] c_op_branch = 7'b1100011;
  localparam logic [6:0] c_op_jal    = 7'b1101111;
  localparam logic [6:0] c_op_jalr   = 7'b1100111;
  localparam logic [6:0] c_op_load   = 7'b0000011;
  localparam logic [6:0] c_op_store  = 7'b0100011;
  localparam logic [6:0] c_op_imm    = 7'b0010011;
  localparam logic [6:0] c_op_reg    = 7'b0110011;
  localparam logic [6:0] c_op_lui    = 7'b0110111;
  localparam logic [6:0] c_op_auipc  = 7'b0010111;
endpackage

module decoder #(
  parameter int CTRL_W = decode_pkg::CTRL_BUS
) (
  input  logic [6:0]        opcode_i,
  input  logic [2:0]        funct3_i,
  input  logic              was_fetched_i,
  output logic [CTRL_W-1:0] ctrl_o
);
  import decode_pkg::*;

  always_comb begin
    ctrl_o = '0;
    if (was_fetched_i) begin
      case (opcode_i)
        c_op_branch: begin
          // funct3 010/011 are unassigned branch encodings
          if (funct3_i == 3'b010 || funct3_i == 3'b011) ctrl_o[c_illegal] = 1'b1;
          else                                          ctrl_o[c_cond_branch] = 1'b1;
        end
        c_op_jal:              ctrl_o[c_jal] = 1'b1;
        c_op_jalr: begin
          if (funct3_i == 3'b000) ctrl_o[c_jalr] = 1'b1;
          else                    ctrl_o[c_illegal] = 1'b1;
        end
        c_op_load:             ctrl_o[c_load]  = 1'b1;
        c_op_store:            ctrl_o[c_store] = 1'b1;
        c_op_imm, c_op_reg:    ctrl_o[c_alu]   = 1'b1;
        c_op_lui, c_op_auipc:  ctrl_o[c_upper] = 1'b1;
        default:               ctrl_o[c_illegal] = 1'b1;
      endcase
    end
  end
endmodule

module decode_stage_n #(
  parameter int LANES  = 2,
  parameter int XLEN   = 32,
  parameter int CTRL_W = decode_pkg::CTRL_BUS
) (
  input  logic                    clock_i,
  input  logic                    reset_i,
  input  logic                    flush_i,
  input  logic                    in_valid_i,
  output logic                    in_ready_o,
  input  logic [LANES*XLEN-1:0]   inst_i,
  input  logic [LANES*XLEN-1:0]   pc_i,
  input  logic [LANES-1:0]        pred_taken_i,
  input  logic [LANES-1:0]        fetched_i,
  output logic                    out_valid_o,
  input  logic                    out_ready_i,
  output logic [LANES*XLEN-1:0]   out_inst_o,
  output logic [LANES*XLEN-1:0]   out_pc_o,
  output logic [LANES*CTRL_W-1:0] out_ctrl_o,
  output logic [LANES-1:0]        out_lane_valid_o,
  output logic [LANES-1:0]        out_pred_taken_o,
  output logic                    redirect_o,
  output logic [XLEN-1:0]         redirect_pc_o
);
  import decode_pkg::*;

  logic [LANES*CTRL_W-1:0] w_ctrl;
  logic [LANES-1:0]        w_lane_valid;
  logic [LANES-1:0]        w_pred;
  logic                    w_seen;
  logic                    w_sel_cf;
  logic [XLEN-1:0]         w_sel_pc;
  logic                    w_bogus;
  logic                    w_accept;
  logic [XLEN-1:0]         w_redirect_pc;

  logic                    r_out_valid;
  logic [LANES*XLEN-1:0]   r_inst;
  logic [LANES*XLEN-1:0]   r_pc;
  logic [LANES*CTRL_W-1:0] r_ctrl;
  logic [LANES-1:0]        r_lane_valid;
  logic [LANES-1:0]        r_pred;
  logic                    r_redirect;
  logic [XLEN-1:0]         r_redirect_pc;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    decoder #(.CTRL_W(CTRL_W)) u_dec (
      .opcode_i      (inst_i[g*XLEN +: 7]),
      .funct3_i      (inst_i[g*XLEN+12 +: 3]),
      .was_fetched_i (fetched_i[g]),
      .ctrl_o        (w_ctrl[g*CTRL_W +: CTRL_W])
    );
  end

  // Walk lanes oldest-first; the first fetched predicted-taken lane ends the bundle.
  always_comb begin
    w_seen       = 1'b0;
    w_sel_cf     = 1'b0;
    w_sel_pc     = '0;
    w_lane_valid = '0;
    w_pred       = '0;
    for (int l = 0; l < LANES; l++) begin
      if (!w_seen) begin
        w_lane_valid[l] = fetched_i[l];
        if (pred_taken_i[l] && fetched_i[l]) begin
          w_seen    = 1'b1;
          w_pred[l] = 1'b1;
          w_sel_pc  = pc_i[l*XLEN +: XLEN];
          w_sel_cf  = w_ctrl[l*CTRL_W + c_cond_branch] | w_ctrl[l*CTRL_W + c_jal]
                    | w_ctrl[l*CTRL_W + c_jalr];
        end
      end
    end
    w_bogus = w_seen && !w_sel_cf;
    if (w_bogus) w_pred = '0;
  end

  assign w_redirect_pc = w_sel_pc + XLEN'(4);
  assign in_ready_o    = !r_out_valid || out_ready_i;
  assign w_accept      = in_valid_i && in_ready_o && !flush_i && !r_redirect;

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      r_out_valid   <= 1'b0;
      r_inst        <= '0;
      r_pc          <= '0;
      r_ctrl        <= '0;
      r_lane_valid  <= '0;
      r_pred        <= '0;
      r_redirect    <= 1'b0;
      r_redirect_pc <= '0;
    end else begin
      r_redirect <= w_accept && w_bogus;
      if (w_accept && w_bogus) r_redirect_pc <= w_redirect_pc;
      if (flush_i) begin
        r_out_valid  <= 1'b0;
        r_lane_valid <= '0;
      end else if (w_accept) begin
        r_out_valid  <= 1'b1;
        r_inst       <= inst_i;
        r_pc         <= pc_i;
        r_ctrl       <= w_ctrl;
        r_lane_valid <= w_lane_valid;
        r_pred       <= w_pred;
      end else if (out_ready_i) begin
        r_out_valid  <= 1'b0;
      end
    end
  end

  assign out_valid_o      = r_out_valid;
  assign out_inst_o       = r_inst;
  assign out_pc_o         = r_pc;
  assign out_ctrl_o       = r_ctrl;
  assign out_lane_valid_o = r_lane_valid;
  assign out_pred_taken_o = r_pred;
  assign redirect_o       = r_redirect;
  assign redirect_pc_o    = r_redirect_pc;
endmodule
`default_nettype wire

// File: tb/tb_decode_stage_n.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_decode_stage_n : scoreboard bench for a 2-lane and a 4-lane instance.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_decode_stage_n;
  localparam logic [31:0] ADDI = 32'h00100093, NOP = 32'h00000013, BEQ = 32'h00000463;
  localparam logic [31:0] JAL = 32'h0080006F, LW = 32'h00002083, SW = 32'h00102023;
  localparam logic [31:0] LUI = 32'h000010B7, AUIPC = 32'h00000117, JALR = 32'h000080E7;
  localparam logic [31:0] BADBR = 32'h00002063, ILL = 32'hFFFFFFFF;

  typedef struct packed {
    logic [63:0] inst;
    logic [63:0] pc;
    logic [15:0] ctrl;
    logic [1:0]  lv;
    logic [1:0]  pt;
  } bundle_t;

  logic clk = 1'b0, rst = 1'b1, flush = 1'b0;
  logic in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1, redirect;
  logic [63:0] inst = '0, pc = '0, out_inst, out_pc;
  logic [1:0]  pred = '0, fet = '0, out_lv, out_pt;
  logic [15:0] out_ctrl;
  logic [31:0] redirect_pc;

  logic in_valid4 = 1'b0, in_ready4, out_valid4, redirect4;
  logic [127:0] inst4 = '0, pc4 = '0, out_inst4, out_pc4;
  logic [3:0]   pred4 = '0, fet4 = '0, out_lv4, out_pt4;
  logic [31:0]  out_ctrl4;
  logic [31:0]  redirect_pc4;

  int errors = 0, checks = 0;
  bundle_t sb[$];
  bundle_t exp_b;
  logic [$bits(bundle_t)-1:0] got_b;

  always #5 clk = ~clk;

  decode_stage_n #(.LANES(2), .XLEN(32)) dut2 (
    .clock_i(clk), .reset_i(rst), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .inst_i(inst), .pc_i(pc), .pred_taken_i(pred), .fetched_i(fet), .out_valid_o(out_valid),
    .out_ready_i(out_ready), .out_inst_o(out_inst), .out_pc_o(out_pc), .out_ctrl_o(out_ctrl),
    .out_lane_valid_o(out_lv), .out_pred_taken_o(out_pt), .redirect_o(redirect),
    .redirect_pc_o(redirect_pc));

  decode_stage_n #(.LANES(4), .XLEN(32)) dut4 (
    .clock_i(clk), .reset_i(rst), .flush_i(1'b0), .in_valid_i(in_valid4), .in_ready_o(in_ready4),
    .inst_i(inst4), .pc_i(pc4), .pred_taken_i(pred4), .fetched_i(fet4), .out_valid_o(out_valid4),
    .out_ready_i(1'b1), .out_inst_o(out_inst4), .out_pc_o(out_pc4), .out_ctrl_o(out_ctrl4),
    .out_lane_valid_o(out_lv4), .out_pred_taken_o(out_pt4), .redirect_o(redirect4),
    .redirect_pc_o(redirect_pc4));

  function automatic logic [7:0] m_ctrl(input logic [31:0] ins, input logic f);
    if (!f) return 8'h00;
    case (ins[6:0])
      7'b1100011: return (ins[14:12] == 3'b010 || ins[14:12] == 3'b011) ? 8'h80 : 8'h01;
      7'b1101111: return 8'h02;
      7'b1100111: return (ins[14:12] == 3'b000) ? 8'h04 : 8'h80;
      7'b0000011: return 8'h08;
      7'b0100011: return 8'h10;
      7'b0010011, 7'b0110011: return 8'h20;
      7'b0110111, 7'b0010111: return 8'h40;
      default: return 8'h80;
    endcase
  endfunction

  function automatic bundle_t model(input logic [63:0] i, input logic [63:0] p,
                                    input logic [1:0] pr, input logic [1:0] fe);
    bundle_t b;
    logic seen;
    b = '0; b.inst = i; b.pc = p; seen = 1'b0;
    for (int l = 0; l < 2; l++) begin
      b.ctrl[l*8 +: 8] = m_ctrl(i[l*32 +: 32], fe[l]);
      if (!seen) begin
        b.lv[l] = fe[l];
        if (pr[l] && fe[l]) begin
          seen = 1'b1;
          b.pt[l] = ((b.ctrl[l*8 +: 8] & 8'h07) != 8'h00);
        end
      end
    end
    return b;
  endfunction

  // Scoreboard: pop one expected bundle per handshake on the 2-lane instance.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      checks++;
      got_b = {out_inst, out_pc, out_ctrl, out_lv, out_pt};
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: got bundle %h, required none", got_b);
      end else begin
        exp_b = sb.pop_front();
        if (got_b !== exp_b) begin
          errors++;
          $display("FAIL sb_bundle: got %h required %h", got_b, exp_b);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic drive2(input logic [31:0] i0, input logic [31:0] i1, input logic [31:0] p0,
                        input logic [31:0] p1, input logic [1:0] pr, input logic [1:0] fe,
                        input bit push);
    inst = {i1, i0}; pc = {p1, p0}; pred = pr; fet = fe; in_valid = 1'b1;
    if (push) sb.push_back(model(inst, pc, pred, fet));
  endtask

  task automatic test_reset();
    rst = 1'b1; tick(); tick();
    checks++; if ({out_valid, out_lv, out_pt, redirect} !== 6'b0) begin errors++;
      $display("FAIL reset_ctl2: got %b required 0", {out_valid, out_lv, out_pt, redirect}); end
    checks++; if ({out_inst, out_pc, out_ctrl, redirect_pc} !== '0) begin errors++;
      $display("FAIL reset_data2: got %h required 0", {out_inst, out_pc, out_ctrl, redirect_pc}); end
    checks++; if ({out_valid4, out_lv4, out_pt4, redirect4, redirect_pc4, out_inst4} !== '0) begin
      errors++; $display("FAIL reset_4: got %h required 0",
                         {out_valid4, out_lv4, out_pt4, redirect4, redirect_pc4, out_inst4}); end
    rst = 1'b0;
  endtask

  task automatic test_no_taken();
    out_ready = 1'b1;
    drive2(ADDI, LW, 32'h200, 32'h204, 2'b00, 2'b11, 1); tick(); in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || redirect !== 1'b0) begin errors++;
      $display("FAIL no_taken_load: got v=%b r=%b required v=1 r=0", out_valid, redirect); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++;
      $display("FAIL no_taken_drain: got %b required 0", out_valid); end
  endtask

  task automatic test_masking();
    drive2(BEQ, ADDI, 32'h300, 32'h304, 2'b11, 2'b11, 1); tick(); in_valid = 1'b0;
    checks++; if (out_lv !== 2'b01 || out_pt !== 2'b01) begin errors++;
      $display("FAIL mask_lanes: got lv=%b pt=%b required 01/01", out_lv, out_pt); end
    checks++; if (redirect !== 1'b0) begin errors++; $display("FAIL mask_redir0: got %b required 0", redirect); end
    tick();
    checks++; if (redirect !== 1'b0) begin errors++; $display("FAIL mask_redir1: got %b required 0", redirect); end
  endtask

  task automatic test_bogus();
    drive2(ADDI, ADDI, 32'h100, 32'h104, 2'b01, 2'b11, 1); tick();
    checks++; if (out_lv !== 2'b01 || out_pt !== 2'b00) begin errors++;
      $display("FAIL bogus_lanes: got lv=%b pt=%b required 01/00", out_lv, out_pt); end
    drive2(JAL, ADDI, 32'h400, 32'h404, 2'b00, 2'b11, 0);
    checks++; if (redirect !== 1'b1 || redirect_pc !== 32'h104) begin errors++;
      $display("FAIL bogus_redirect: got r=%b pc=%h required 1/00000104", redirect, redirect_pc); end
    tick(); in_valid = 1'b0;
    checks++; if (redirect !== 1'b0 || out_valid !== 1'b0 || redirect_pc !== 32'h104) begin errors++;
      $display("FAIL bogus_drop: got r=%b v=%b pc=%h required 0/0/00000104", redirect, out_valid, redirect_pc); end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    drive2(LUI, AUIPC, 32'h600, 32'h604, 2'b00, 2'b11, 1); tick();
    drive2(SW, BEQ, 32'h700, 32'h704, 2'b10, 2'b11, 0);
    for (int i = 0; i < 3; i++) begin
      checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_pc !== 64'h00000604_00000600) begin
        errors++; $display("FAIL bp_hold%0d: got rdy=%b v=%b pc=%h required 0/1/0000060400000600",
                           i, in_ready, out_valid, out_pc); end
      tick();
    end
    out_ready = 1'b1; sb.push_back(model(inst, pc, pred, fet)); #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release: got %b required 1", in_ready); end
    tick(); in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_pc !== 64'h00000704_00000700) begin errors++;
      $display("FAIL bp_swap: got v=%b pc=%h required 1/0000070400000700", out_valid, out_pc); end
    tick();
  endtask

  task automatic test_flush();
    drive2(ADDI, ADDI, 32'h500, 32'h504, 2'b10, 2'b11, 0); flush = 1'b1; tick();
    flush = 1'b0; in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0 || redirect !== 1'b0) begin errors++;
      $display("FAIL flush_race: got v=%b r=%b required 0/0", out_valid, redirect); end
    tick();
    checks++; if (redirect !== 1'b0) begin errors++; $display("FAIL flush_race_late: got %b required 0", redirect); end
    out_ready = 1'b0;
    drive2(JAL, NOP, 32'h800, 32'h804, 2'b01, 2'b11, 1); tick(); in_valid = 1'b0; flush = 1'b1; tick();
    flush = 1'b0; sb.delete(); out_ready = 1'b1;
    checks++; if (out_valid !== 1'b0 || out_lv !== 2'b00) begin errors++;
      $display("FAIL flush_held: got v=%b lv=%b required 0/00", out_valid, out_lv); end
    drive2(NOP, NOP, 32'h900, 32'h904, 2'b01, 2'b11, 1); tick(); in_valid = 1'b0; flush = 1'b1;
    checks++; if (redirect !== 1'b1 || redirect_pc !== 32'h904) begin errors++;
      $display("FAIL flush_redir_live: got r=%b pc=%h required 1/00000904", redirect, redirect_pc); end
    tick(); flush = 1'b0;
    checks++; if (redirect !== 1'b0 || out_valid !== 1'b0) begin errors++;
      $display("FAIL flush_redir_end: got r=%b v=%b required 0/0", redirect, out_valid); end
  endtask

  task automatic test_empty();
    drive2(ADDI, ADDI, 32'hA00, 32'hA04, 2'b11, 2'b00, 1); tick(); in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_lv !== 2'b00 || out_pt !== 2'b00 || redirect !== 1'b0) begin
      errors++; $display("FAIL empty_bubble: got v=%b lv=%b pt=%b r=%b required 1/00/00/0",
                         out_valid, out_lv, out_pt, redirect); end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [31:0] tbl [8];
    tbl = '{ADDI, LW, SW, LUI, JALR, BADBR, ILL, JAL};
    for (int i = 0; i < 6; i++) begin
      drive2(tbl[$urandom_range(0, 7)], tbl[$urandom_range(0, 7)], $urandom, $urandom,
             2'b00, 2'($urandom_range(0, 3)), 1);
      tick();
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid%0d: got %b required 1", i, out_valid); end
    end
    in_valid = 1'b0; tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_end: got %b required 0", out_valid); end
  endtask

  task automatic test_reset_mid();
    drive2(ADDI, ADDI, 32'hB00, 32'hB04, 2'b00, 2'b11, 1); tick();
    drive2(ADDI, ADDI, 32'hC00, 32'hC04, 2'b01, 2'b11, 0); rst = 1'b1; tick();
    rst = 1'b0; in_valid = 1'b0; sb.delete();
    checks++; if ({out_valid, out_lv, out_pt, redirect, redirect_pc, out_inst, out_pc, out_ctrl} !== '0) begin
      errors++; $display("FAIL reset_mid: got v=%b lv=%b r=%b rpc=%h required all 0",
                         out_valid, out_lv, redirect, redirect_pc); end
    tick();
    checks++; if (redirect !== 1'b0) begin errors++; $display("FAIL reset_mid_redir: got %b required 0", redirect); end
  endtask

  task automatic test_wrap4();
    inst4 = {NOP, NOP, NOP, LW}; pc4 = {32'h4C, 32'h48, 32'h44, 32'h40};
    pred4 = 4'b0001; fet4 = 4'b1111; in_valid4 = 1'b1; tick(); in_valid4 = 1'b0;
    checks++; if (out_lv4 !== 4'b0001 || out_pt4 !== 4'b0000 || redirect4 !== 1'b1 || redirect_pc4 !== 32'h44) begin
      errors++; $display("FAIL l4_load: got lv=%b pt=%b r=%b pc=%h required 0001/0000/1/00000044",
                         out_lv4, out_pt4, redirect4, redirect_pc4); end
    tick();
    inst4 = {BEQ, NOP, ADDI, ADDI}; pc4 = {32'h0, 32'hFFFFFFFC, 32'hFFFFFFF8, 32'hFFFFFFF4};
    pred4 = 4'b1100; fet4 = 4'b1111; in_valid4 = 1'b1; tick(); in_valid4 = 1'b0;
    checks++; if (out_valid4 !== 1'b1 || out_lv4 !== 4'b0111 || out_pt4 !== 4'b0000) begin errors++;
      $display("FAIL l4_wrap_lanes: got v=%b lv=%b pt=%b required 1/0111/0000", out_valid4, out_lv4, out_pt4); end
    checks++; if (redirect4 !== 1'b1 || redirect_pc4 !== 32'h0) begin errors++;
      $display("FAIL l4_wrap_pc: got r=%b pc=%h required 1/00000000", redirect4, redirect_pc4); end
    tick();
    checks++; if (redirect4 !== 1'b0) begin errors++; $display("FAIL l4_pulse: got %b required 0", redirect4); end
  endtask

  initial begin
    test_reset();
    test_no_taken();
    test_masking();
    test_bogus();
    test_backpressure();
    test_flush();
    test_empty();
    test_back_to_back();
    test_wrap4();
    test_reset_mid();
    tick();
    checks++; if (sb.size() != 0) begin errors++;
      $display("FAIL sb_leftover: got %0d pending required 0", sb.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/decode_stage_n.md
Name: decode_stage_n

Overview:
- Parametrised N-lane decode stage for the superscalar front end, sitting between the fetch buffer and issue.
- Decodes up to LANES instructions per cycle with one `decoder` instance per lane.
- Keeps only the first predicted-taken lane in a bundle and kills all younger lanes.
- Detects predicted-taken non-control-flow instructions and issues a registered redirect.
- Holds decoded bundles in an output pipeline register with a valid/ready handshake and flush support.

Parameters:
- LANES, 2, number of instruction lanes per bundle (1..8).
- XLEN, 32, instruction and PC width.
- CTRL_W, width of `CTRL_BUS, decoder control-word width per lane.

Ports:
- clock_i  in  1  system clock.
- reset_i  in  1  synchronous active-high reset.
- flush_i  in  1  pipeline flush from the backend; highest priority after reset.
- in_valid_i  in  1  fetch bundle valid.
- in_ready_o  out  1  stage can accept a bundle this cycle.
- inst_i  in  LANES*XLEN  instructions; lane 0 = oldest, in the LSBs.
- pc_i  in  LANES*XLEN  per-lane PCs.
- pred_taken_i  in  LANES  per-lane predictor taken bits.
- fetched_i  in  LANES  per-lane fetched-valid bits; passed to decoder was_fetched_i.
- out_valid_o  out  1  decoded bundle valid.
- out_ready_i  in  1  issue accepts the bundle.
- out_inst_o  out  LANES*XLEN  registered instructions.
- out_pc_o  out  LANES*XLEN  registered PCs.
- out_ctrl_o  out  LANES*CTRL_W  registered control words.
- out_lane_valid_o  out  LANES  registered per-lane valid after masking.
- out_pred_taken_o  out  LANES  registered masked prediction bits.
- redirect_o  out  1  one-cycle fetch redirect pulse.
- redirect_pc_o  out  XLEN  redirect target.

Behaviour:
- Reset values: all outputs are 0. Reset also clears the output register and any pending redirect.
- Acceptance:
  - in_ready_o = !out_valid_o || out_ready_i, combinational.
  - accept = in_valid_i && in_ready_o && !flush_i && !redirect_o.
- Prediction masking (combinational on inputs):
  - f = lowest lane with pred_taken_i && fetched_i.
  - Lanes > f get lane_valid = 0 and pred_taken = 0.
  - Lanes <= f get lane_valid = fetched_i.
  - Only lane f keeps pred_taken.
- Bogus-taken detection:
  - Lane f is bogus if its control word has none of COND_BRANCH, JAL or JALR set.
  - On accept with a bogus lane f:
    - lane f stays valid in the bundle with pred_taken cleared;
    - next cycle redirect_o = 1 and redirect_pc_o = pc of lane f + 4 (XLEN wrap-around).
  - redirect_o lasts exactly one cycle.
- Wrong-path drop:
  - While redirect_o = 1, the incoming bundle is wrong-path.
  - It is not accepted (accept = 0); in_ready_o may still read 1.
- Latency: one cycle from accept to out_valid_o.
- Output register:
  - On accept, load the decoded bundle and set out_valid_o.
  - Else if out_ready_i, clear out_valid_o.
  - Else hold all outputs stable.
  - Simultaneous drain and accept is supported (full throughput).
- Flush:
  - flush_i clears out_valid_o, out_lane_valid_o and any pending redirect on the next edge.
  - A redirect_o scheduled for the following cycle is suppressed.
  - A redirect already high in the flush cycle completes that cycle only.
- Empty bundle: an accepted bundle with every fetched_i = 0 is still loaded, with out_lane_valid_o = 0 (a bubble).
- No taken lane: all fetched lanes stay valid and no redirect is issued.
- Backpressure: while out_valid_o && !out_ready_i, inputs are ignored and outputs stay stable.
- redirect_pc_o holds its last value when redirect_o = 0; only redirect_o is qualifying.

Test Plan:
- Reset mid-bundle: assert reset_i while out_valid_o = 1 and a redirect is pending -> next cycle all outputs are 0 and no redirect pulse follows.
- LANES=2 masking: both lanes fetched, lane 0 = BEQ predicted taken, lane 1 = ADDI predicted taken -> out_lane_valid_o = 2'b01, out_pred_taken_o = 2'b01, no redirect.
- Bogus taken: lane 0 = ADDI at pc 0x100 with pred_taken = 1 -> lane 0 valid with pred_taken cleared; next cycle redirect_o = 1 and redirect_pc_o = 0x104; the bundle presented during the pulse is dropped.
- Backpressure: hold out_ready_i = 0 for 3 cycles with in_valid_i = 1 -> in_ready_o = 0 and outputs stable. Release -> the next bundle loads in the same cycle the old one drains.
- Flush racing redirect: accept a bogus-taken bundle and assert flush_i the same cycle -> no redirect_o, out_valid_o = 0 next cycle.
- LANES=4 wrap: lane 2 = NOP predicted taken at pc 0xFFFFFFFC -> lanes 0-2 valid, lane 3 masked, redirect_pc_o = 0x00000000.
